// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count, flush and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata is registered.
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   localparam int CW       = $clog2(DEPTH) + 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rdata,
   input  logic             flush,
   input  logic             clr_err,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] LP_AF    = CW'(AF_THRESH);
   localparam logic [CW-1:0] LP_AE    = CW'(AE_THRESH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_full;
   logic             w_empty;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic             w_ovf_set;
   logic             w_udf_set;

   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);

   // flush suppresses both ports and any error they would otherwise raise
   assign w_rd_acc  = rd_en & ~w_empty & ~flush;
   assign w_wr_acc  = wr_en & (~w_full | w_rd_acc) & ~flush;
   assign w_ovf_set = wr_en & ~w_wr_acc & ~flush;
   assign w_udf_set = rd_en & w_empty & ~flush;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // a new error in the same cycle as clr_err keeps the flag set
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_ovf_set | (r_overflow & ~clr_err);
         r_underflow <= w_udf_set | (r_underflow & ~clr_err);
      end
   end

`ifdef FIFO_FWFT_EN
   assign rdata = r_mem[r_rd_ptr];
`else
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_rdata <= '0;
      end else if (w_rd_acc) begin
         r_rdata <= r_mem[r_rd_ptr];
      end
   end

   assign rdata = r_rdata;
`endif

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= LP_AF);
   assign almost_empty = (r_count <= LP_AE);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16).
// Read sampling adapts to FIFO_FWFT_EN so the same scenarios cover both read modes.
module tb_sync_fifo_param;

   logic       clk;
   logic       res;
   logic       wr_en;
   logic [7:0] wdata;
   logic       rd_en;
   logic [7:0] rdata;
   logic       flush;
   logic       clr_err;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_checks;
   int n_fail;

   sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
      .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata),
      .flush(flush), .clr_err(clr_err), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1;
      wdata = d;
      tick();
      wr_en = 1'b0;
   endtask

   // returns the word popped by one accepted read
   task automatic pop(output logic [7:0] d);
`ifdef FIFO_FWFT_EN
      d = rdata;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
`else
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      d = rdata;
`endif
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
          almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         $display("FAIL reset_flags got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b exp cnt=0 e=1 ae=1 f=0 af=0 ov=0 un=0",
                  count, empty, almost_empty, full, almost_full, overflow, underflow);
         n_fail++;
      end
`ifndef FIFO_FWFT_EN
      n_checks++;
      if (rdata !== 8'h00) begin
         $display("FAIL reset_rdata got=%0h exp=0", rdata);
         n_fail++;
      end
`endif
   endtask

   task automatic test_fill_drain();
      logic [7:0] d;
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         n_checks++;
         if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i + 1 == 16) ||
             almost_empty !== (i + 1 <= 2) || empty !== 1'b0) begin
            $display("FAIL fill_%0d got cnt=%0d af=%b f=%b ae=%b e=%b exp cnt=%0d af=%b f=%b ae=%b e=0",
                     i, count, almost_full, full, almost_empty, empty, i + 1, (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2));
            n_fail++;
         end
      end
      push(8'hEE);
      n_checks++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         $display("FAIL overflow_17th got ov=%b cnt=%0d exp ov=1 cnt=16", overflow, count);
         n_fail++;
      end
      for (int i = 0; i < 16; i++) begin
         pop(d);
         n_checks++;
         if (d !== 8'(i) || count !== 5'(15 - i)) begin
            $display("FAIL drain_%0d got data=%0h cnt=%0d exp data=%0h cnt=%0d", i, d, count, i, 15 - i);
            n_fail++;
         end
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_checks++;
      if (underflow !== 1'b1 || empty !== 1'b1 || count !== 5'd0) begin
         $display("FAIL underflow_extra got un=%b e=%b cnt=%0d exp un=1 e=1 cnt=0", underflow, empty, count);
         n_fail++;
      end
`ifndef FIFO_FWFT_EN
      n_checks++;
      if (rdata !== 8'h0F) begin
         $display("FAIL rdata_hold got=%0h exp=f", rdata);
         n_fail++;
      end
`endif
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         $display("FAIL clr_err_both got ov=%b un=%b exp ov=0 un=0", overflow, underflow);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
      for (int k = 0; k < 20; k++) begin
         wdata = 8'h30 + 8'(k);
         wr_en = 1'b1;
`ifdef FIFO_FWFT_EN
         d = rdata;
         rd_en = 1'b1;
         tick();
`else
         rd_en = 1'b1;
         tick();
         d = rdata;
`endif
         n_checks++;
         if (d !== 8'h20 + 8'(k) || count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            $display("FAIL stream_%0d got data=%0h cnt=%0d f=%b ov=%b exp data=%0h cnt=16 f=1 ov=0",
                     k, d, count, full, overflow, 8'h20 + 8'(k));
            n_fail++;
         end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         pop(d);
         n_checks++;
         if (d !== 8'h34 + 8'(i)) begin
            $display("FAIL stream_tail_%0d got=%0h exp=%0h", i, d, 8'h34 + 8'(i));
            n_fail++;
         end
      end
      n_checks++;
      if (empty !== 1'b1) begin
         $display("FAIL stream_empty got=%b exp=1", empty);
         n_fail++;
      end
   endtask

   task automatic test_wrap();
      logic [7:0] d;
      logic [7:0] exp_q[$];
      logic [7:0] e;
      for (int i = 0; i < 3; i++) begin
         push(8'h70 + 8'(i));
         exp_q.push_back(8'h70 + 8'(i));
      end
      for (int k = 0; k < 40; k++) begin
         wdata = 8'h80 + 8'(k);
         wr_en = 1'b1;
         exp_q.push_back(8'h80 + 8'(k));
`ifdef FIFO_FWFT_EN
         d = rdata;
         rd_en = 1'b1;
         tick();
`else
         rd_en = 1'b1;
         tick();
         d = rdata;
`endif
         e = exp_q.pop_front();
         n_checks++;
         if (d !== e || count !== 5'd3) begin
            $display("FAIL wrap_%0d got data=%0h cnt=%0d exp data=%0h cnt=3", k, d, count, e);
            n_fail++;
         end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pop(d);
         e = exp_q.pop_front();
         n_checks++;
         if (d !== e) begin
            $display("FAIL wrap_tail_%0d got=%0h exp=%0h", i, d, e);
            n_fail++;
         end
      end
   endtask

   task automatic test_flush_clear();
      logic [7:0] d;
      logic [7:0] held;
      for (int i = 0; i < 10; i++) push(8'h90 + 8'(i));
      pop(d);
      held = rdata;
      flush = 1'b1;
      wr_en = 1'b1;
      wdata = 8'h55;
      tick();
      flush = 1'b0;
      wr_en = 1'b0;
      n_checks++;
      if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
         $display("FAIL flush_at9 got cnt=%0d e=%b ov=%b exp cnt=0 e=1 ov=0", count, empty, overflow);
         n_fail++;
      end
`ifndef FIFO_FWFT_EN
      n_checks++;
      if (rdata !== held) begin
         $display("FAIL flush_rdata_hold got=%0h exp=%0h", rdata, held);
         n_fail++;
      end
`endif
      for (int i = 0; i < 16; i++) push(8'(i));
      flush = 1'b1;
      wr_en = 1'b1;
      tick();
      flush = 1'b0;
      wr_en = 1'b0;
      n_checks++;
      if (count !== 5'd0 || overflow !== 1'b0) begin
         $display("FAIL flush_full_wr got cnt=%0d ov=%b exp cnt=0 ov=0", count, overflow);
         n_fail++;
      end
      flush = 1'b1;
      rd_en = 1'b1;
      tick();
      flush = 1'b0;
      rd_en = 1'b0;
      n_checks++;
      if (underflow !== 1'b0 || empty !== 1'b1) begin
         $display("FAIL flush_empty_rd got un=%b e=%b exp un=0 e=1", underflow, empty);
         n_fail++;
      end
      // empty with read and write together: write lands, underflow still sets
      rd_en = 1'b1;
      wr_en = 1'b1;
      wdata = 8'h3C;
      tick();
      rd_en = 1'b0;
      wr_en = 1'b0;
      n_checks++;
      if (underflow !== 1'b1 || count !== 5'd1) begin
         $display("FAIL empty_rw got un=%b cnt=%0d exp un=1 cnt=1", underflow, count);
         n_fail++;
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      for (int i = 0; i < 15; i++) push(8'(i));
      push(8'hFF);
      n_checks++;
      if (overflow !== 1'b1) begin
         $display("FAIL ovf_set got=%b exp=1", overflow);
         n_fail++;
      end
      clr_err = 1'b1;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      n_checks++;
      if (overflow !== 1'b1) begin
         $display("FAIL clr_vs_set got=%b exp=1", overflow);
         n_fail++;
      end
      tick();
      clr_err = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0 || count !== 5'd16) begin
         $display("FAIL clr_err_pulse got ov=%b un=%b cnt=%0d exp ov=0 un=0 cnt=16", overflow, underflow, count);
         n_fail++;
      end
      do_flush();
   endtask

   task automatic test_async_reset();
      logic [7:0] d;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
      pop(d);
      n_checks++;
      if (count !== 5'd7 || underflow !== 1'b1 || d !== 8'hB0) begin
         $display("FAIL pre_reset got cnt=%0d un=%b data=%0h exp cnt=7 un=1 data=b0", count, underflow, d);
         n_fail++;
      end
      #2;
      res = 1'b0;
      #1;
      n_checks++;
      if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
          almost_full !== 1'b0 || underflow !== 1'b0 || overflow !== 1'b0) begin
         $display("FAIL async_reset got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b exp cnt=0 e=1 ae=1 f=0 af=0 ov=0 un=0",
                  count, empty, almost_empty, full, almost_full, overflow, underflow);
         n_fail++;
      end
`ifndef FIFO_FWFT_EN
      n_checks++;
      if (rdata !== 8'h00) begin
         $display("FAIL async_reset_rdata got=%0h exp=0", rdata);
         n_fail++;
      end
`endif
      @(negedge clk);
      res = 1'b1;
      tick();
      push(8'hC1);
      push(8'hC2);
      pop(d);
      n_checks++;
      if (d !== 8'hC1) begin
         $display("FAIL refill_0 got=%0h exp=c1", d);
         n_fail++;
      end
      pop(d);
      n_checks++;
      if (d !== 8'hC2 || empty !== 1'b1) begin
         $display("FAIL refill_1 got data=%0h e=%b exp data=c2 e=1", d, empty);
         n_fail++;
      end
   endtask

`ifdef FIFO_FWFT_EN
   task automatic test_fwft();
      push(8'hA5);
      n_checks++;
      if (rdata !== 8'hA5 || empty !== 1'b0) begin
         $display("FAIL fwft_head got data=%0h e=%b exp data=a5 e=0", rdata, empty);
         n_fail++;
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_checks++;
      if (empty !== 1'b1) begin
         $display("FAIL fwft_pop got e=%b exp=1", empty);
         n_fail++;
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      res      = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wdata    = 8'h00;
      flush    = 1'b0;
      clr_err  = 1'b0;
      #1;
      test_reset();
      #20;
      @(negedge clk);
      res = 1'b1;
      tick();
      test_fill_drain();
      test_back_to_back();
      test_wrap();
      test_flush_clear();
      test_async_reset();
`ifdef FIFO_FWFT_EN
      test_fwft();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
